// File: rtl/mac_patch_feeder.sv
// rtl/mac_patch_feeder.sv - 4x4 stride-2 patch builder and 3x3 weight holder feeding a MAC bank
//
// Loads nine conv weights, then accepts a raster pixel stream. Three line buffers
// (rows r-1, r-2, r-3) and a 4x4 shift window build each patch. One patch is
// emitted per valid window position, with a one-cycle o_acc_valid pulse.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   i_start      begin weight load + frame (IDLE only)
//   i_wgt_valid  weight byte strobe (LOAD_W only)
//   i_wgt        weight byte, w0..w8 row-major
//   i_pix_valid  pixel strobe
//   i_pix        pixel byte, raster order
//   o_pix_ready  pixel accepted when i_pix_valid & o_pix_ready
//   o_din        patch, byte k = window(row k/4, col k%4)
//   o_weight     byte j = weight j
//   o_acc_valid  one-cycle pulse, o_din holds a new window
//   o_busy       high in any state but IDLE
//   o_done       one-cycle pulse after the last pixel of the frame
module mac_patch_feeder #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_wgt_valid,
    input  logic [7:0]   i_wgt,
    input  logic         i_pix_valid,
    input  logic [7:0]   i_pix,
    output logic         o_pix_ready,
    output logic [127:0] o_din,
    output logic [71:0]  o_weight,
    output logic         o_acc_valid,
    output logic         o_busy,
    output logic         o_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(3);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [3:0]     r_wgt_cnt;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic           r_pix_ready;
    logic [127:0]   r_din;
    logic [71:0]    r_weight;
    logic           r_acc_valid;
    logic           r_busy;
    logic           r_done;

    // Line buffers hold the previous three rows at each column; not reset.
    logic [7:0]     r_lb_m1 [IMG_W];
    logic [7:0]     r_lb_m2 [IMG_W];
    logic [7:0]     r_lb_m3 [IMG_W];

    // Window row 0 is the oldest row (r-3), column 3 the newest column.
    logic [7:0]     r_win [4][4];
    logic [7:0]     w_win_next [4][4];
    logic [127:0]   w_din_next;

    logic           w_accept;
    logic           w_emit;
    logic           w_last_pix;

    assign w_accept   = (r_state == S_RUN) && i_pix_valid && r_pix_ready;
    // (r-3) and (c-3) even means r and c are odd.
    assign w_emit     = (r_row >= ROW_FIRST_WIN) && (r_col >= COL_FIRST_WIN)
                        && r_row[0] && r_col[0];
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
        end
        w_win_next[0][3] = r_lb_m3[r_col];
        w_win_next[1][3] = r_lb_m2[r_col];
        w_win_next[2][3] = r_lb_m1[r_col];
        w_win_next[3][3] = i_pix;
    end

    always_comb begin
        w_din_next = '0;
        for (int k = 0; k < 16; k++) begin
            w_din_next[8*k +: 8] = w_win_next[k/4][k%4];
        end
    end

    // Column-wise shift of the line buffers: each row moves one slot older.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_lb_m3[r_col] <= r_lb_m2[r_col];
            r_lb_m2[r_col] <= r_lb_m1[r_col];
            r_lb_m1[r_col] <= i_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wgt_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pix_ready <= 1'b0;
            r_din       <= '0;
            r_weight    <= '0;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_acc_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_LOAD_W;
                        r_busy    <= 1'b1;
                        r_wgt_cnt <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (i_wgt_valid) begin
                        for (int j = 0; j < 9; j++) begin
                            if (r_wgt_cnt == 4'(j)) begin
                                r_weight[8*j +: 8] <= i_wgt;
                            end
                        end
                        if (r_wgt_cnt == 4'd8) begin
                            r_state     <= S_RUN;
                            r_pix_ready <= 1'b1;
                            r_col       <= '0;
                            r_row       <= '0;
                        end else begin
                            r_wgt_cnt <= r_wgt_cnt + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_win <= w_win_next;
                        if (w_emit) begin
                            r_din       <= w_din_next;
                            r_acc_valid <= 1'b1;
                        end
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_last_pix) begin
                            r_state     <= S_DONE;
                            r_pix_ready <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pix_ready = r_pix_ready;
    assign o_din       = r_din;
    assign o_weight    = r_weight;
    assign o_acc_valid = r_acc_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_mac_patch_feeder.sv
// tb/tb_mac_patch_feeder.sv - scoreboard bench for mac_patch_feeder
module tb_mac_patch_feeder;

    localparam int W = 8;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic         i_wgt_valid;
    logic [7:0]   i_wgt;
    logic         i_pix_valid;
    logic [7:0]   i_pix;
    logic         o_pix_ready;
    logic [127:0] o_din;
    logic [71:0]  o_weight;
    logic         o_acc_valid;
    logic         o_busy;
    logic         o_done;

    mac_patch_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_wgt_valid (i_wgt_valid),
        .i_wgt       (i_wgt),
        .i_pix_valid (i_pix_valid),
        .i_pix       (i_pix),
        .o_pix_ready (o_pix_ready),
        .o_din       (o_din),
        .o_weight    (o_weight),
        .o_acc_valid (o_acc_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] din;
        int           cyc;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [127:0] seen[$];
    logic [7:0]   frame [H][W];
    int           n_chk = 0;
    int           n_fail = 0;
    int           pulses = 0;
    int           done_cnt = 0;
    bit           chk_busy = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected window per pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_busy) begin
                check("busy_after_done", o_busy, 0);
                chk_busy = 0;
            end
            if (o_acc_valid) begin
                pulses++;
                seen.push_back(o_din);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("window", o_din, mon_e.din);
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("done_with_pulse", o_done, mon_e.last);
                end
            end else if (o_done) begin
                check("done_without_pulse", 1, 0);
            end
            if (o_done) begin
                done_cnt++;
                chk_busy = 1;
            end
        end
    end

    function automatic logic [127:0] win_at(input int r, input int c);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = frame[r-3+k/4][c-3+k%4];
        return v;
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = 8'(W*r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = 8'($urandom);
    endtask

    task automatic load_weights(input logic [71:0] w);
        @(negedge clk); i_start = 1;
        @(negedge clk); i_start = 0;
        check("busy_in_load", o_busy, 1);
        for (int j = 0; j < 9; j++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                i_wgt_valid = 0;
                i_pix_valid = 1;
                i_pix = 8'($urandom);
                check("ready_in_load", o_pix_ready, 0);
            end
            @(negedge clk);
            i_pix_valid = 0;
            i_wgt_valid = 1;
            i_wgt = w[8*j +: 8];
        end
        @(negedge clk);
        i_wgt_valid = 0;
        check("weights", o_weight, w);
        check("ready_in_run", o_pix_ready, 1);
        i_wgt_valid = 1;
        i_wgt = ~w[7:0];
        @(negedge clk);
        i_wgt_valid = 0;
        check("weights_after_extra", o_weight, w);
    endtask

    // mode 0: back-to-back, 1: valid toggles 1-0-1-0, 2: random gaps
    task automatic run_frame(input int mode, input bit inject_start, input int stop_at);
        exp_t e;
        int   gaps;
        for (int p = 0; p < W*H; p++) begin
            int r, c;
            if (p == stop_at) break;
            r = p / W;
            c = p % W;
            gaps = (mode == 1) ? (p > 0 ? 1 : 0) : (mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (gaps) begin
                @(negedge clk);
                i_pix_valid = 0;
                i_pix = 8'($urandom);
                i_start = inject_start && ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            i_start = inject_start && ($urandom_range(0, 3) == 0);
            i_pix_valid = 1;
            i_pix = frame[r][c];
            if (!o_pix_ready) begin
                check("ready_during_frame", 0, 1);
                i_pix_valid = 0;
                break;
            end
            if (r >= 3 && c >= 3 && (r-3) % 2 == 0 && (c-3) % 2 == 0) begin
                e.din  = win_at(r, c);
                e.cyc  = cyc + 1;
                e.last = (p == W*H - 1);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        i_pix_valid = 0;
        i_start = 0;
    endtask

    task automatic finish_frame(input int d0, input int p0);
        int t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        check("windows_per_frame", pulses - p0, ((W-4)/2+1)*((H-4)/2+1));
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_din"}, o_din, 0);
        check({tag, "_weight"}, o_weight, 0);
        check({tag, "_acc_valid"}, o_acc_valid, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_ready"}, o_pix_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic pattern_frame(input int mode);
        int d0, p0;
        fill_pattern();
        load_weights(72'h090807060504030201);
        seen.delete();
        d0 = done_cnt;
        p0 = pulses;
        run_frame(mode, 0, -1);
        finish_frame(d0, p0);
        check("seen_count", seen.size(), 9);
        if (seen.size() == 9) begin
            check("w0_byte0", seen[0][7:0], 0);
            check("w0_byte3", seen[0][31:24], 3);
            check("w0_byte12", seen[0][103:96], 24);
            check("w0_byte15", seen[0][127:120], 27);
            check("w2_byte0", seen[2][7:0], 4);
            check("w2_byte15", seen[2][127:120], 31);
            check("w8_byte0", seen[8][7:0], 36);
            check("w8_byte15", seen[8][127:120], 63);
        end
        check("weights_held", o_weight, 72'h090807060504030201);
    endtask

    initial begin
        logic [71:0] w;
        int d0, p0;
        rst = 1;
        i_start = 0;
        i_wgt_valid = 0;
        i_wgt = 0;
        i_pix_valid = 0;
        i_pix = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        pattern_frame(0);
        pattern_frame(1);

        // Reset in the middle of a frame, then a clean pattern frame.
        w = {$urandom, $urandom, $urandom};
        fill_random();
        load_weights(w);
        run_frame(0, 0, 20);
        @(negedge clk); rst = 1;
        @(negedge clk);
        check_reset_outputs("midreset");
        check("midreset_no_pending", exp_q.size(), 0);
        rst = 0;
        pattern_frame(0);

        // Random frames with random valid gaps and stray i_start during RUN.
        for (int f = 0; f < 3; f++) begin
            w = {$urandom, $urandom, $urandom};
            fill_random();
            load_weights(w);
            d0 = done_cnt;
            p0 = pulses;
            run_frame(2, 1, -1);
            finish_frame(d0, p0);
            check("weights_after_random", o_weight, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
